// File: rtl/prog_chain_loader_if.sv
// rtl/prog_chain_loader_if.sv - config word valid/ready channel feeding the chain loader
interface prog_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/prog_chain_loader.sv
// rtl/prog_chain_loader.sv - serialises config words onto the programmable-element scan chain
// Optional readback of the old chain contents via prog_tail when PROG_READBACK_EN is defined.
module prog_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  localparam int BL_W     = $clog2(CHAIN_LEN + 1),
  localparam int CW       = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  prog_chain_loader_if.slave cfg,
  output logic              prog_en,
  output logic              prog_in,
  input  logic              prog_tail,
  output logic              busy,
  output logic              done,
  output logic [BL_W-1:0]   bits_left,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [WORD_W-1:0] sr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     first_cnt;

  // The last word may be shorter than WORD_W; its upper bits are never shifted.
  assign first_cnt = (int'(bits_left) < WORD_W) ? CW'(bits_left) : CW'(WORD_W);

  assign cfg.cfg_ready = (state == S_LOAD);
  assign prog_en       = (state == S_SHIFT);
  assign prog_in       = (state == S_SHIFT) & sr[0];
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      cnt       <= '0;
      bits_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            bits_left <= BL_W'(CHAIN_LEN);
          end
        end
        S_LOAD: begin
          if (cfg.cfg_valid) begin
            sr    <= cfg.cfg_data;
            cnt   <= first_cnt;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr        <= sr >> 1;
          cnt       <= cnt - CW'(1);
          bits_left <= bits_left - BL_W'(1);
          if (cnt == CW'(1)) begin
            state <= (bits_left == BL_W'(1)) ? S_DONE : S_LOAD;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PROG_READBACK_EN
  logic [WORD_W-1:0] rb_acc;
  logic [WORD_W-1:0] rb_next;
  logic [CW-1:0]     rb_idx;

  // First bit out of the tail lands in bit 0, matching cfg_data order.
  assign rb_next = rb_acc | (WORD_W'(prog_tail) << rb_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_acc   <= '0;
      rb_idx   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == S_LOAD) begin
        rb_acc <= '0;
        rb_idx <= '0;
      end else if (state == S_SHIFT) begin
        rb_acc <= rb_next;
        rb_idx <= rb_idx + CW'(1);
        if (cnt == CW'(1)) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = prog_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_chain_loader.sv
// tb/tb_prog_chain_loader.sv - directed and randomized checks of prog_chain_loader against a bit-stream model
module tb_prog_chain_loader;
  localparam int CHAIN_LEN = 10;
  localparam int WORD_W    = 8;
  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BL_W      = $clog2(CHAIN_LEN + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic prog_en, prog_in, prog_tail, busy, done, rb_valid;
  logic [BL_W-1:0]   bits_left;
  logic [WORD_W-1:0] rb_data;

  prog_chain_loader_if #(.WORD_W(WORD_W)) cfg ();

  prog_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg       (cfg),
    .prog_en   (prog_en),
    .prog_in   (prog_in),
    .prog_tail (prog_tail),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Chain model: prog_in enters the head, bit 0 is the tail.
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] preload_val;
  logic                 preload_req = 1'b0;
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (prog_en) chain <= {prog_in, chain[CHAIN_LEN-1:1]};
  end
  assign prog_tail = chain[0];

  int cyc = 0;
  int done_cnt = 0;
  int rb_total = 0;
  logic              q_bits[$];
  int                en_cycles[$];
  logic [WORD_W-1:0] rb_q[$];
  always @(negedge clk) begin
    cyc++;
    if (prog_en === 1'b1) begin
      q_bits.push_back(prog_in);
      en_cycles.push_back(cyc);
    end
    if (rb_valid === 1'b1) begin
      rb_q.push_back(rb_data);
      rb_total++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [CHAIN_LEN-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/prog_en"},   32'(prog_en), 0);
    check({tag, "/prog_in"},   32'(prog_in), 0);
    check({tag, "/busy"},      32'(busy), 0);
    check({tag, "/done"},      32'(done), 0);
    check({tag, "/cfg_ready"}, 32'(cfg.cfg_ready), 0);
    check({tag, "/bits_left"}, 32'(bits_left), 0);
    check({tag, "/rb"},        32'({rb_valid, rb_data}), 0);
  endtask

  task automatic run_load(input string name, input logic [N_WORDS*WORD_W-1:0] words,
                          input int stall, input bit spurious);
    int base_b, base_e, base_r, base_d, guard, n_en;
    bit hs;
    logic [CHAIN_LEN-1:0] old_chain;
    logic [CHAIN_LEN-1:0] obs_vec;
    logic [WORD_W-1:0]    exp_rb;
    logic [BL_W-1:0]      bl_hold;
    base_b = q_bits.size();
    base_e = en_cycles.size();
    base_r = rb_q.size();
    base_d = done_cnt;
    old_chain = chain;

    start = 1'b1;
    step();
    start = 1'b0;
    check({name, "/bits_left_init"}, 32'(bits_left), CHAIN_LEN);
    check({name, "/busy_load"}, 32'(busy), 1);

    for (int k = 0; k < N_WORDS; k++) begin
      if (k > 0 && stall > 0) begin
        guard = 0;
        while (cfg.cfg_ready !== 1'b1 && guard < 100) begin step(); guard++; end
        bl_hold = bits_left;
        for (int s = 0; s < stall; s++) begin
          check({name, "/stall_prog_en"}, 32'(prog_en), 0);
          check({name, "/stall_bits_left"}, 32'(bits_left), 32'(bl_hold));
          step();
        end
      end
      cfg.cfg_data  = words[k*WORD_W +: WORD_W];
      cfg.cfg_valid = 1'b1;
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 200) begin
        hs = (cfg.cfg_ready === 1'b1);
        step();
        guard++;
      end
      check({name, "/handshake"}, 32'(hs), 1);
      if (stall > 0 || k == N_WORDS - 1) cfg.cfg_valid = 1'b0;
      if (spurious && k == 0) begin
        step(); step(); step();
        bl_hold = bits_left;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, "/spurious_bits_left"}, 32'(bits_left), 32'(bl_hold) - 1);
        check({name, "/spurious_prog_en"}, 32'(prog_en), 1);
      end
    end

    guard = 0;
    while (done !== 1'b1 && guard < 200) begin step(); guard++; end
    check({name, "/done_seen"}, 32'(done), 1);
    check({name, "/busy_in_done"}, 32'(busy), 1);
    step();
    check({name, "/done_after"}, 32'(done), 0);
    check({name, "/busy_after"}, 32'(busy), 0);
    check({name, "/bits_left_end"}, 32'(bits_left), 0);

    n_en = en_cycles.size() - base_e;
    check({name, "/prog_en_cycles"}, 32'(n_en), CHAIN_LEN);
    obs_vec = '0;
    for (int i = 0; i < CHAIN_LEN; i++)
      if (base_b + i < q_bits.size()) obs_vec[i] = q_bits[base_b + i];
    check({name, "/bit_stream"}, 32'(obs_vec), 32'(words[CHAIN_LEN-1:0]));
    if (stall == 0 && n_en > 0)
      check({name, "/span"}, 32'(en_cycles[en_cycles.size()-1] - en_cycles[base_e] + 1),
            CHAIN_LEN + N_WORDS - 1);
    check({name, "/done_pulses"}, 32'(done_cnt - base_d), 1);
    check({name, "/chain_contents"}, 32'(chain), 32'(words[CHAIN_LEN-1:0]));
`ifdef PROG_READBACK_EN
    check({name, "/rb_count"}, 32'(rb_q.size() - base_r), N_WORDS);
    for (int k = 0; k < N_WORDS; k++) begin
      exp_rb = '0;
      for (int j = 0; j < WORD_W; j++)
        if (k*WORD_W + j < CHAIN_LEN) exp_rb[j] = old_chain[k*WORD_W + j];
      if (base_r + k < rb_q.size())
        check({name, "/rb_word"}, 32'(rb_q[base_r + k]), 32'(exp_rb));
    end
`else
    exp_rb = '0;
    check({name, "/rb_count"}, 32'(rb_q.size() - base_r), 0);
`endif
  endtask

  initial begin
    logic [N_WORDS*WORD_W-1:0] w;
    int guard, base_e, stall;
    rst_n = 1'b0;
    start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    #1;
    check_all_zero("reset");
    preload(CHAIN_LEN'($urandom));
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("idle");

    run_load("basic", 16'h03A5, 0, 1'b0);
    run_load("backpressure", 16'h03A5, 5, 1'b0);
    run_load("partial", 16'hFFA5, 0, 1'b0);
    run_load("spurious", 16'h035A, 0, 1'b1);

    base_e = en_cycles.size();
    start = 1'b1;
    step();
    start = 1'b0;
    cfg.cfg_data  = 8'h3C;
    cfg.cfg_valid = 1'b1;
    guard = 0;
    while (en_cycles.size() - base_e < 4 && guard < 100) begin step(); guard++; end
    check("abort/bits_shifted", 32'(en_cycles.size() - base_e), 4);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    cfg.cfg_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_load("after_reset", 16'h01C3, 0, 1'b0);

    preload(10'h2B5);
    run_load("readback", 16'h0296, 0, 1'b0);
`ifdef PROG_READBACK_EN
    check("readback/word0", 32'(rb_q[rb_q.size()-2]), 32'h0B5);
    check("readback/word1", 32'(rb_q[rb_q.size()-1]), 32'h002);
`endif

    for (int r = 0; r < 6; r++) begin
      w = (N_WORDS*WORD_W)'($urandom);
      stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      run_load("random", w, stall, 1'($urandom_range(0, 1)));
    end

`ifndef PROG_READBACK_EN
    check("no_readback/rb_valid_total", 32'(rb_total), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
